mips_lsu: RTL
=============

Name: mips_lsu

Overview:
Parametrised load/store unit sitting between the MIPS core datapath and the byte-lane data memory. It replaces the core's direct word-only memory hookup with a handshaked request/response interface. Supports byte, halfword and word accesses, plus doubleword when the bus allows it, with sign or zero extension. Sub-word stores use read-modify-write, because the memory has only a whole-word write enable.

Parameters:
NUM_BYTES, 4, byte lanes per memory word; legal values 4 or 8; DATA_W = 8*NUM_BYTES.
ADDR_W, 32, byte-address width.
MEM_LATENCY, 1, cycles from a stable mem_addr to valid mem_data_out; legal range 0..7.

Ports:
clk  in  1  clock.
rst_b  in  1  asynchronous active-low reset.
halted  in  1  core halted; blocks new requests.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  access size is 2^req_size bytes.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned access or oversize access.
mem_addr  out  ADDR_W  word-aligned address (low log2(NUM_BYTES) bits are 0).
mem_data_out  in  8 x [0:NUM_BYTES-1]  read lanes.
mem_data_in  out  8 x [0:NUM_BYTES-1]  write lanes.
mem_write_en  out  1  whole-word write strobe.

Behaviour:
- Lane ordering is big-endian: byte offset k maps to lane k, and lane 0 holds the MSBs.
- Reset (asynchronous, active-low):
  - state goes to IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, mem_write_en=0.
  - resp_rdata=0, mem_addr=0, mem_data_in all 0.
  - A reset mid-operation abandons the access; mem_write_en drops immediately.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
- IDLE:
  - req_ready = !halted.
  - A transfer happens on req_valid && req_ready.
  - Error case: 2^req_size > NUM_BYTES, or req_addr is not a multiple of the access size. Go to RESP with resp_err=1. No memory access is made.
  - Full-word store: latch data, go to WRITE.
  - Load or sub-word store: latch the request, load cnt=MEM_LATENCY, go to RD_WAIT.
- RD_WAIT:
  - mem_addr is held.
  - While cnt!=0, decrement cnt.
  - When cnt==0, capture mem_data_out. The state therefore lasts MEM_LATENCY+1 cycles.
  - Load: extract the lanes at the offset, extend per req_signed, go to RESP.
  - Store: replace the addressed lanes with the low bytes of req_wdata, keep the other lanes, go to WRITE.
- WRITE: mem_write_en=1 for exactly one cycle with the merged word on mem_data_in, then go to RESP. mem_data_in holds its value after WRITE.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable until resp_ready.
  - On the handshake, return to IDLE. The next request can be accepted on the following cycle (no same-cycle accept).
- Latency from the accept cycle to the first resp_valid cycle:
  - Load: MEM_LATENCY+2.
  - Full-word store: 2.
  - Sub-word store: MEM_LATENCY+3.
  - Error: 1.
- halted asserting outside IDLE does not abort the access in flight; it only blocks the next accept.

Optional Feature:
LSU_PERF_EN
- Defined: adds outputs perf_loads, perf_stores and perf_errs (32 bits each).
  - Each counter increments on the RESP handshake of the matching kind.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mips_lsu_pkg holds:
  - lsu_state_e (IDLE, RD_WAIT, WRITE, RESP).
  - lsu_size_e (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3).
  - A byte_t typedef.
  - The localparam for the lane-index width.
- Sub-module mips_lsu_lane: purely combinational.
  - Extract and extend: (word, offset, size, signed) -> rdata.
  - Merge: (word, offset, size, wdata) -> merged word.
  - Instantiated once in the FSM module.

Test Plan:
- Sign-extended LB, NUM_BYTES=4, MEM_LATENCY=1. Memory word at 0x100 holds lanes {0x12,0x34,0x56,0x80}; request LB signed at 0x103. Expect mem_addr=0x100, resp_rdata=0xFFFFFF80, resp_err=0, resp_valid 3 cycles after accept.
- Zero-extended LHU on the same word at 0x102. Expect resp_rdata=0x00005680.
- SB 0xAB to 0x101 on the same word. Expect one read, then a single mem_write_en pulse with lanes {0x12,0xAB,0x56,0x80}; resp_valid 4 cycles after accept.
- SW 0xDEADBEEF to 0x200. Expect no read wait, mem_write_en pulse on the cycle after accept with lanes {DE,AD,BE,EF}, resp_valid the cycle after that.
- Error cases: LW at 0x102 or LD with NUM_BYTES=4 -> resp_err=1, resp_rdata=0, mem_write_en never asserted, resp_valid the cycle after accept. resp_ready held low for 5 cycles -> resp_valid and data stable throughout.
- Reset and halt: rst_b low during WRITE -> mem_write_en=0 immediately and state returns to IDLE. halted=1 in IDLE -> req_ready=0 and req_valid is ignored.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared types and constants for the mips_lsu load/store unit
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef logic [7:0] byte_t;

  // Wide enough to index any lane of the widest (8-lane) bus.
  localparam int LANE_IDX_W = 3;

  // Access size in bytes for an encoded req_size.
  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// rtl/mips_lsu_lane.sv - combinational lane extract/extend and store merge (big-endian lanes)
module mips_lsu_lane
  import mips_lsu_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  localparam int DATA_W = 8 * NUM_BYTES
) (
  input  logic [DATA_W-1:0]     word,
  input  logic [LANE_IDX_W-1:0] offset,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic [DATA_W-1:0]     merged
);

  // Lane k occupies bits [DATA_W-1-8k -: 8], so lane 0 is the MSB byte.
  int                nbytes;
  int                base;
  logic [DATA_W-1:0] field;
  logic              sign;

  // Extract: shift the addressed lanes down to the LSBs, then sign- or zero-fill above them.
  always_comb begin
    nbytes = size_bytes(size);
    if (nbytes > NUM_BYTES) nbytes = NUM_BYTES;
    base = NUM_BYTES - int'(offset) - nbytes;
    if (base < 0) base = 0;
    field = word >> (8 * base);
    sign  = is_signed && field[8*nbytes-1];
    rdata = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      rdata[8*i +: 8] = (i < nbytes) ? field[8*i +: 8] : {8{sign}};
    end
  end

  // Merge: overwrite the addressed lanes with the low bytes of wdata, keep the rest of the word.
  always_comb begin
    merged = word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (i >= int'(offset) && i < int'(offset) + nbytes) begin
        merged[DATA_W-1-8*i -: 8] = wdata[8*(int'(offset) + nbytes - 1 - i) +: 8];
      end
    end
  end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - handshaked load/store unit with read-modify-write sub-word stores; LSU_PERF_EN adds perf counters
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int NUM_BYTES   = 4,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1,
  localparam int DATA_W = 8 * NUM_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    halted,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_W-1:0]       mem_addr,
  input  byte_t [0:NUM_BYTES-1]   mem_data_out,
  output byte_t [0:NUM_BYTES-1]   mem_data_in,
`ifdef LSU_PERF_EN
  output logic [31:0]             perf_loads,
  output logic [31:0]             perf_stores,
  output logic [31:0]             perf_errs,
`endif
  output logic                    mem_write_en
);

  localparam int OFF_W = $clog2(NUM_BYTES);

  lsu_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [LANE_IDX_W-1:0] off_q, off_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     memin_q, memin_d;

  logic [DATA_W-1:0]     lane_rdata;
  logic [DATA_W-1:0]     lane_merged;

  int                    req_nbytes;
  logic                  req_bad;
  logic                  req_full;
  logic                  accept;

  mips_lsu_lane #(.NUM_BYTES(NUM_BYTES)) u_lane (
    .word      (mem_data_out),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (sgn_q),
    .wdata     (wdata_q),
    .rdata     (lane_rdata),
    .merged    (lane_merged)
  );

  assign req_ready    = (state_q == IDLE) && !halted;
  assign accept       = req_valid && req_ready;
  assign resp_valid   = (state_q == RESP);
  assign mem_write_en = (state_q == WRITE);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign mem_addr     = addr_q;
  assign mem_data_in  = memin_q;

  // Classify the incoming request: oversize or misaligned is an error, full-word stores skip the read.
  always_comb begin
    req_nbytes = size_bytes(req_size);
    req_bad    = (req_nbytes > NUM_BYTES) ||
                 ((int'(req_addr[2:0]) & (req_nbytes - 1)) != 0);
    req_full   = (req_nbytes == NUM_BYTES);
  end

  // Next-state and datapath for the IDLE/RD_WAIT/WRITE/RESP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    addr_d  = addr_q;
    memin_d = memin_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          off_d   = LANE_IDX_W'(req_addr[OFF_W-1:0]);
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (req_write && req_full) begin
              memin_d = req_wdata;
              state_d = WRITE;
            end else begin
              cnt_d   = 3'(MEM_LATENCY);
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (write_q) begin
          memin_d = lane_merged;
          state_d = WRITE;
        end else begin
          rdata_d = lane_rdata;
          state_d = RESP;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      memin_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      memin_q <= memin_d;
    end
  end

`ifdef LSU_PERF_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stores_q, perf_stores_d;
  logic [31:0] perf_errs_q, perf_errs_d;

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errs   = perf_errs_q;

  // Saturating counters bumped once per completed response, by response kind.
  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    perf_errs_d   = perf_errs_q;
    if (state_q == RESP && resp_ready) begin
      if (err_q) begin
        if (perf_errs_q != 32'hFFFF_FFFF) perf_errs_d = perf_errs_q + 32'd1;
      end else if (write_q) begin
        if (perf_stores_q != 32'hFFFF_FFFF) perf_stores_d = perf_stores_q + 32'd1;
      end else begin
        if (perf_loads_q != 32'hFFFF_FFFF) perf_loads_d = perf_loads_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_errs_q   <= '0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
      perf_errs_q   <= perf_errs_d;
    end
  end
`endif

endmodule
